// File: rtl/shift_left_logical_seq_8bit.sv
// Sequential logical-left shifter: shifts the captured operand one bit per clock.
// It reports the result, the last bit shifted out, and a busy/done handshake.
module shift_left_logical_seq_8bit #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [AMT_W-1:0] amt,
  output logic [WIDTH-1:0] f,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state_reg;
  logic [WIDTH-1:0]   f_reg;
  logic               cout_reg;
  logic [AMT_W-1:0]   cnt_reg;
  logic               busy_reg;
  logic               done_reg;
  logic [AMT_W-1:0]   amt_clamped;

  // Shifting by more than WIDTH is indistinguishable from shifting by WIDTH.
  always_comb begin
    amt_clamped = amt;
    if (amt > AMT_W'(WIDTH)) amt_clamped = AMT_W'(WIDTH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      f_reg     <= '0;
      cout_reg  <= 1'b0;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            f_reg    <= x;
            cout_reg <= 1'b0;
            cnt_reg  <= amt_clamped;
            busy_reg <= 1'b1;
            if (amt_clamped == '0) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= SHIFT;
            end
          end
        end
        SHIFT: begin
          cout_reg <= f_reg[WIDTH-1];
          f_reg    <= {f_reg[WIDTH-2:0], 1'b0};
          cnt_reg  <= cnt_reg - AMT_W'(1);
          if (cnt_reg == AMT_W'(1)) begin
            state_reg <= DONE;
            done_reg  <= 1'b1;
          end
        end
        DONE: begin
          // start is deliberately ignored here; a new op needs an IDLE cycle.
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign f    = f_reg;
  assign cout = cout_reg;
  assign busy = busy_reg;
  assign done = done_reg;

endmodule

// File: doc/shift_left_logical_seq_8bit.md
# shift_left_logical_seq_8bit

Sequential logical-left shifter, the left-direction partner to the existing 8-bit logical right shifter in the lab ALU datapath. It loads an operand and a shift amount on a start strobe, shifts one bit per clock, and reports the result, the last bit shifted out, and completion through a busy/done handshake. It is used where a multi-bit left shift is spread over cycles instead of built as a barrel shifter.

## Interface

Parameters:
- WIDTH, 8, operand/result width.
- AMT_W, 4, shift-amount width; must be able to encode WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous reset, active-low; one clock domain only.
- start  input  1  request; sampled only when busy=0.
- x  input  WIDTH  operand, captured on accepted start.
- amt  input  AMT_W  shift amount, captured on accepted start.
- f  output  WIDTH  result register; holds its value until the next accepted start.
- cout  output  1  last bit shifted out of f[WIDTH-1]; 0 if no shift was performed.
- busy  output  1  high while state is not IDLE.
- done  output  1  one-cycle completion pulse.

## Operation

- States: IDLE, SHIFT, DONE.
- IDLE: busy=0, done=0. On a rising edge with start=1:
  - f <= x, cout <= 0, cnt <= min(amt, WIDTH).
  - Next state is DONE if the clamped amt is 0, otherwise SHIFT.
- SHIFT: on each edge:
  - cout <= f[WIDTH-1].
  - f <= {f[WIDTH-2:0], 1'b0}.
  - cnt <= cnt-1.
  - When cnt==1 at the edge, next state is DONE.
- DONE: done=1 and busy=1 for exactly one cycle, then unconditionally IDLE.
- Amount clamping: amt > WIDTH is treated as WIDTH. Result is f=0 and cout=x[0], not 0.
- Result equation for clamped amount N (0..WIDTH):
  - f = x << N, zero-filled.
  - cout = x[WIDTH-N] for N≥1; cout = 0 for N=0.
- start while busy=1, including the DONE cycle, is ignored. It is neither queued nor allowed to alter x/amt capture.
- x and amt may change freely after the accepting edge without affecting the operation in flight.
- Intermediate f/cout values are visible during SHIFT. Consumers must qualify them with done.
- Reset: rst_n=0 asynchronously forces state=IDLE, f=0, cout=0, cnt=0, busy=0, done=0, regardless of state, including mid-SHIFT. The first start accepted after deassertion behaves normally.

## Timing

- Edge 0 is the edge that accepts start. Edges 1..N perform the N shifts.
- done is high in the cycle following edge N, i.e. N+1 edges after start including the accepting edge.
  - N=0: done is high in the cycle right after edge 0.
  - N=WIDTH: done is high after edge 8.
- busy rises after edge 0 and falls after the edge that ends the DONE cycle (edge N+1).
- Throughput: a new start is accepted at edge N+2 at the earliest. Back-to-back ops are separated by one IDLE cycle.
- Outputs are all registered or decoded from registered state only. There is no combinational path from inputs to outputs.

## Test plan

- Reset: assert rst_n=0 asynchronously mid-cycle -> f=8'h00, cout=0, busy=0, done=0 immediately, without waiting for a clock edge.
- x=8'b11111101, amt=1 -> done after edge 1, f=8'b11111010, cout=1; busy high for 2 cycles.
- x=8'b10001110, amt=3 -> done after edge 3, f=8'b01110000, cout=0.
  - Also check intermediate f=8'b00011100 after edge 1 and f=8'b00111000 after edge 2.
- x=8'b11001101, amt=0 -> done after edge 0, f=8'b11001101, cout=0, no shift cycles.
- x=8'b10001111, amt=8, then again with amt=13 -> both: done after edge 8, f=8'h00, cout=1 (clamped).
- Two illegal sequences, each run from a fresh start:
  - Pulse start with different x during SHIFT and during DONE -> ignored; the original result is kept.
  - Drop rst_n after edge 2 of an amt=5 op -> all outputs 0, state IDLE. A following start with x=8'h01, amt=7 then gives f=8'h80, cout=0.
